// File: rtl/s2p_cond.sv
// Four-lane serial-to-parallel receiver: finds comma-aligned byte boundaries, confirms
// alignment over LOCK_COUNT commas, then strobes out one reassembled byte per lane.
module s2p_cond #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       IN_CLK_s2p,
  input  logic       IN_RESET_s2p,
  input  logic       IN_ENB_s2p,
  input  logic [3:0] IN_LANE_s2p,
  output logic [7:0] OUT_LANE3_s2p,
  output logic [7:0] OUT_LANE2_s2p,
  output logic [7:0] OUT_LANE1_s2p,
  output logic [7:0] OUT_LANE0_s2p,
  output logic       OUT_VALID_s2p,
  output logic       OUT_LOCK_s2p,
  output logic [2:0] OUT_CTR_s2p
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  state_e          state_q, state_d;
  logic [3:0][6:0] sh_q;
  logic [3:0][7:0] cand;
  logic [3:0][7:0] out_q, out_d;
  logic [3:0]      com_hit;
  logic [2:0]      ctr_q, ctr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            lock_q;
  logic            all_com, any_com, boundary;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cand[n]    = {sh_q[n], IN_LANE_s2p[n]};
      com_hit[n] = (cand[n] == COM);
    end
    all_com  = &com_hit;
    any_com  = |com_hit;
    boundary = (ctr_q == 3'd7);
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    if (IN_ENB_s2p) begin
      ctr_d = ctr_q + 3'd1;
      case (state_q)
        StSearch: begin
          // Search realigns on any edge, not only at the current boundary.
          if (all_com) begin
            ctr_d   = 3'd0;
            cnt_d   = 4'd1;
            state_d = StVerify;
          end
        end
        StVerify: begin
          if (boundary) begin
            if (all_com) begin
              cnt_d = cnt_q + 4'd1;
              if (cnt_q + 4'd1 == LockCnt) state_d = StLocked;
            end else begin
              cnt_d   = 4'd0;
              state_d = StSearch;
            end
          end
        end
        StLocked: begin
          if (boundary) begin
            if (any_com && !all_com) begin
              cnt_d   = 4'd0;
              state_d = StSearch;
            end else begin
              out_d   = cand;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge IN_CLK_s2p or posedge IN_RESET_s2p) begin
    if (IN_RESET_s2p) begin
      state_q <= StSearch;
      sh_q    <= '0;
      ctr_q   <= 3'd0;
      cnt_q   <= 4'd0;
      out_q   <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      lock_q  <= (state_d == StLocked);
      if (IN_ENB_s2p) begin
        for (int n = 0; n < 4; n++) sh_q[n] <= cand[n][6:0];
      end
    end
  end

  assign OUT_LANE3_s2p = out_q[3];
  assign OUT_LANE2_s2p = out_q[2];
  assign OUT_LANE1_s2p = out_q[1];
  assign OUT_LANE0_s2p = out_q[0];
  assign OUT_VALID_s2p = valid_q;
  assign OUT_LOCK_s2p  = lock_q;
  assign OUT_CTR_s2p   = ctr_q;

endmodule
